// File: rtl/cdc_pkg.sv
// Shared types for the req/ack bus synchroniser pair (cdc_hs_tx / cdc_hs_rx).
// Handshake state encoding and default abort timeout.
package cdc_pkg;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_REQ,
        HS_RELEASE
    } hs_state_t;

    localparam int HS_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for signals crossing into the clk domain.
// Async active-low reset clears both stages.
module sync2 #(
    parameter int SIZE = 1
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    logic [SIZE-1:0] meta;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a 4-phase req/ack single-word bus synchroniser.
// Optional ack timeout abort enabled by defining CDC_HS_TX_TIMEOUT_EN.
module cdc_hs_tx
    import cdc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = HS_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             x_req,
    output logic [WIDTH-1:0] x_data,
    input  logic             x_ack,
    output logic             busy,
    output logic             err
);

    hs_state_t state;
    hs_state_t state_nxt;
    logic      req_nxt;
    logic      load;
    logic      ack_s;
    logic      err_nxt;

    sync2 #(.SIZE(1)) u_ack_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (x_ack),
        .q     (ack_s)
    );

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (state == HS_REQ && !ack_s) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err <= 1'b0;
        end else begin
            err <= err_nxt;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= HS_IDLE;
            x_req  <= 1'b0;
            x_data <= '0;
        end else begin
            state <= state_nxt;
            x_req <= req_nxt;
            if (load) begin
                x_data <= s_data;
            end
        end
    end

    // A stale ack left over from a reset blocks new requests
    always_comb begin
        state_nxt = state;
        req_nxt   = x_req;
        load      = 1'b0;
        err_nxt   = 1'b0;
        s_ready   = 1'b0;
        unique case (state)
            HS_IDLE: begin
                s_ready = !ack_s;
                if (s_valid && !ack_s) begin
                    load      = 1'b1;
                    req_nxt   = 1'b1;
                    state_nxt = HS_REQ;
                end
            end
            HS_REQ: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = HS_RELEASE;
                end
`ifdef CDC_HS_TX_TIMEOUT_EN
                else if (cnt == CNT_MAX) begin
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = HS_RELEASE;
                end
`endif
            end
            HS_RELEASE: begin
                if (!ack_s) begin
                    state_nxt = HS_IDLE;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = HS_IDLE;
            end
        endcase
    end

    assign busy = (state != HS_IDLE);

endmodule

// File: doc/cdc_hs_tx.md
Name: cdc_hs_tx

Overview:
- Transmitting end of a 4-phase req/ack bus synchroniser that carries single data words across a clock boundary without a FIFO.
- Lives in the source domain (clk). It accepts a word on a valid/ready interface, holds it stable on x_data, and signals it with x_req.
- It completes the transfer only after a full req↑/ack↑/req↓/ack↓ cycle, with x_ack synchronised locally.
- Pairs with a responder block in the destination domain; used for low-rate config/status words where an async FIFO is overkill.

Parameters:
- WIDTH, 32, data word width in bits.
- TIMEOUT, 1024, cycles to wait for ack↑ before abort; used only when CDC_HS_TX_TIMEOUT_EN is defined; must be ≥ 8.

Ports:
- clk  in  1  source-domain clock.
- n_rst  in  1  reset, asynchronous, active-low.
- s_data  in  WIDTH  word to send.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block can accept a word this cycle.
- x_req  out  1  request to destination domain; register output, glitch-free.
- x_data  out  WIDTH  held data to destination domain; register output.
- x_ack  in  1  acknowledge from destination domain; asynchronous to clk.
- busy  out  1  a transfer is in progress (state != IDLE).
- err  out  1  one-cycle pulse on timeout abort; tied 0 when the macro is absent.

Behaviour:
- Synchronisation: x_ack passes through the codebase's 2-flop synchroniser (sync2, SIZE=1, clk/n_rst) to give ack_s. Nothing else samples x_ack.
- Reset values: state=IDLE, x_req=0, x_data=0, busy=0, err=0, ack_s=0.
- State machine:
  - IDLE: s_ready = !ack_s. On s_valid & s_ready at edge N: x_data<=s_data, x_req<=1, go to REQ. x_req is visible high after edge N (1-cycle latency).
  - REQ: x_req=1, x_data frozen. On ack_s=1: x_req<=0, go to RELEASE.
  - RELEASE: x_req=0, x_data still frozen. On ack_s=0: go to IDLE.
- s_ready is 0 in REQ and RELEASE. s_ready is a pure decode of registered state and ack_s; it has no combinational path from s_valid.
- x_data changes only on acceptance in IDLE. It stays stable from the accepting edge until after ack↓ is seen.
- Back-to-back: with s_valid held high, the next word is accepted in the first IDLE cycle where ack_s=0.
- Minimum transfer, when the responder acks in the same destination cycle: 2 sync cycles for ack↑ plus 2 for ack↓, plus the REQ/RELEASE/IDLE transitions.
- Throughput: at most one word per 4-phase round trip.
- ack_s=1 in IDLE (stale ack, e.g. after local reset mid-transfer): s_ready=0 until ack_s falls. No new req is issued while the remote side is still acking.
- Reset mid-operation: x_req drops to 0 asynchronously and state goes to IDLE. The word being transferred is lost; recovery is as in the previous item.
- s_valid without s_ready: word is not captured and upstream must hold it. s_data changes while s_valid & !s_ready are don't-care.
- An ack_s glitch or ack↑ while in RELEASE has no effect; only ack_s=0 advances.

Optional Feature:
- Macro: CDC_HS_TX_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entry to REQ and increments each REQ cycle with ack_s=0.
  - When it reaches TIMEOUT-1 with ack_s still 0: x_req<=0, err pulses high for exactly 1 cycle, go to RELEASE.
  - From RELEASE, the normal ack_s=0 wait applies.
  - ack_s=1 on the same cycle as expiry takes priority as a normal completion; err stays 0.
- Undefined: no counter; REQ waits indefinitely; err is constant 0.

Decomposition:
- Shared package cdc_pkg holds:
  - typedef enum logic [1:0] {HS_IDLE, HS_REQ, HS_RELEASE} hs_state_t, which the future cdc_hs_rx responder reuses.
  - localparam HS_TIMEOUT_DEFAULT = 1024.
- Sub-module: reuse the existing sync2 for the ack; no new sub-module.

Test Plan:
- Single word: responder acks 1 dst-cycle after req_sync, clocks equal. Send s_data=32'hDEADBEEF → x_req↑ 1 cycle after accept; x_data=DEADBEEF stable until ack_s↓; s_ready returns 1; responder captures DEADBEEF.
- Stream: 16 words 0..15, s_valid held high, clk 100 MHz / dst 37 MHz → all 16 received in order. s_ready never high while ack_s=1. No x_data change while x_req|ack_s.
- Stalled responder: ack withheld 500 cycles → x_req held high, busy=1, s_ready=0 throughout. Ack releases → completes normally with err=0.
- Reset mid-transfer: assert n_rst while in REQ with responder ack=1 → x_req=0 immediately. After reset, s_ready=0 until ack_s=0. The next word is sent correctly.
- Timeout (macro defined, TIMEOUT=16): no ack → x_req falls exactly 16 cycles after entering REQ. err high for 1 cycle. State RELEASE→IDLE; s_ready=1 two cycles later.
- Timeout race (macro defined): ack_s rises on the expiry cycle → err=0, normal completion. With the macro undefined, err stays 0 under no ack for 10000 cycles.
